// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if
// Groups the operand/forwarding/scoreboard signals between the pipeline
// and fwd_hazard_unit.
//   master : pipeline side, drives EX operand ids, forwarding sources,
//            issue/complete events; receives selects, stall and status.
//   slave  : the hazard unit itself.
// Optional macro FWD_PERF_CNT_EN adds the two performance counter outputs.
interface fwd_hazard_unit_if #(
  parameter int NUM_FWD_SRC = 2,
  parameter int REG_AW      = 5,
  parameter int SEL_W       = $clog2(NUM_FWD_SRC + 1)
);
  logic [REG_AW-1:0]             IDEX_rs1_i;
  logic [REG_AW-1:0]             IDEX_rs2_i;
  logic [REG_AW-1:0]             IDEX_rd_i;
  logic                          IDEX_rd_wren_i;
  logic [NUM_FWD_SRC*REG_AW-1:0] fwd_rd_i;
  logic [NUM_FWD_SRC-1:0]        fwd_wren_i;
  logic [NUM_FWD_SRC-1:0]        fwd_valid_i;
  logic                          issue_i;
  logic [REG_AW-1:0]             issue_rd_i;
  logic                          complete_i;
  logic [REG_AW-1:0]             complete_rd_i;
  logic [SEL_W-1:0]              rs1_sel_o;
  logic [SEL_W-1:0]              rs2_sel_o;
  logic                          stall_o;
  logic                          issue_ready_o;
  logic                          sb_err_o;
`ifdef FWD_PERF_CNT_EN
  logic [31:0]                   perf_stall_cnt_o;
  logic [31:0]                   perf_lu_cnt_o;
`endif

  modport master (
`ifdef FWD_PERF_CNT_EN
    input  perf_stall_cnt_o, perf_lu_cnt_o,
`endif
    output IDEX_rs1_i, IDEX_rs2_i, IDEX_rd_i, IDEX_rd_wren_i,
    output fwd_rd_i, fwd_wren_i, fwd_valid_i,
    output issue_i, issue_rd_i, complete_i, complete_rd_i,
    input  rs1_sel_o, rs2_sel_o, stall_o, issue_ready_o, sb_err_o
  );

  modport slave (
`ifdef FWD_PERF_CNT_EN
    output perf_stall_cnt_o, perf_lu_cnt_o,
`endif
    input  IDEX_rs1_i, IDEX_rs2_i, IDEX_rd_i, IDEX_rd_wren_i,
    input  fwd_rd_i, fwd_wren_i, fwd_valid_i,
    input  issue_i, issue_rd_i, complete_i, complete_rd_i,
    output rs1_sel_o, rs2_sel_o, stall_o, issue_ready_o, sb_err_o
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
// Forwarding-select and hazard detection for the EX stage. Picks the
// youngest matching forwarding source per operand, detects load-use
// hazards, and tracks long-latency destinations in a busy scoreboard.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (clears scoreboard and error)
//   bus    : fwd_hazard_unit_if.slave (operands, forwarding sources,
//            issue/complete events, selects, stall, ready, sb_err)
// Optional macro FWD_PERF_CNT_EN adds saturating stall / load-use counters.
module fwd_hazard_unit #(
  parameter int NUM_FWD_SRC     = 2,
  parameter int REG_AW          = 5,
  parameter int MAX_OUTSTANDING = 4,
  parameter int SEL_W           = $clog2(NUM_FWD_SRC + 1)
) (
  input logic              clk_i,
  input logic              rst_ni,
  fwd_hazard_unit_if.slave bus
);
  localparam int NUM_REGS = 2 ** REG_AW;
  localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic                sb_err_q, sb_err_d;

  logic [REG_AW-1:0] src_rd [NUM_FWD_SRC];
  logic [SEL_W-1:0]  rs1_sel, rs2_sel;
  logic              rs1_lu, rs2_lu;
  logic              lu_stall, sb_stall, issue_stall, stall;
  logic              issue_ready;
  logic              complete_ok, issue_room, issue_busy, issue_set;

  // Scan from oldest to youngest so the youngest match overwrites; the
  // load-use flag follows the chosen source, so an older valid copy never
  // hides a younger one still in flight. rd==0 sources never match.
  always_comb begin
    rs1_sel = '0;
    rs2_sel = '0;
    rs1_lu  = 1'b0;
    rs2_lu  = 1'b0;
    for (int k = NUM_FWD_SRC - 1; k >= 0; k--) begin
      src_rd[k] = bus.fwd_rd_i[k*REG_AW +: REG_AW];
      if (bus.fwd_wren_i[k] && src_rd[k] != '0 && src_rd[k] == bus.IDEX_rs1_i) begin
        rs1_sel = SEL_W'(k + 1);
        rs1_lu  = ~bus.fwd_valid_i[k];
      end
      if (bus.fwd_wren_i[k] && src_rd[k] != '0 && src_rd[k] == bus.IDEX_rs2_i) begin
        rs2_sel = SEL_W'(k + 1);
        rs2_lu  = ~bus.fwd_valid_i[k];
      end
    end
  end

  // Stall sources: load-use, scoreboard RAW/WAW, and an issue that the
  // scoreboard cannot take this cycle.
  always_comb begin
    issue_ready = (out_cnt_q < CNT_W'(MAX_OUTSTANDING));
    lu_stall    = rs1_lu | rs2_lu;
    sb_stall    = busy_q[bus.IDEX_rs1_i] | busy_q[bus.IDEX_rs2_i]
                | (bus.IDEX_rd_wren_i & busy_q[bus.IDEX_rd_i]);
    issue_stall = bus.issue_i & ~issue_ready;
    stall       = lu_stall | sb_stall | issue_stall;
  end

  // Scoreboard next state. A valid complete in the same cycle frees a slot
  // and, when it targets the same rd, lets the new issue re-claim it.
  always_comb begin
    busy_d      = busy_q;
    out_cnt_d   = out_cnt_q;
    sb_err_d    = sb_err_q;
    complete_ok = bus.complete_i && bus.complete_rd_i != '0 && busy_q[bus.complete_rd_i];
    issue_room  = issue_ready | complete_ok;
    issue_busy  = busy_q[bus.issue_rd_i]
                & ~(complete_ok && bus.complete_rd_i == bus.issue_rd_i);
    issue_set   = bus.issue_i && issue_room && bus.issue_rd_i != '0 && !issue_busy;

    if (bus.complete_i && !complete_ok) sb_err_d = 1'b1;
    if (bus.issue_i && (!issue_room || (bus.issue_rd_i != '0 && issue_busy)))
      sb_err_d = 1'b1;

    if (complete_ok) busy_d[bus.complete_rd_i] = 1'b0;
    if (issue_set)   busy_d[bus.issue_rd_i]    = 1'b1;

    if (issue_set && !complete_ok)      out_cnt_d = out_cnt_q + CNT_W'(1);
    else if (!issue_set && complete_ok) out_cnt_d = out_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q    <= '0;
      out_cnt_q <= '0;
      sb_err_q  <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      out_cnt_q <= out_cnt_d;
      sb_err_q  <= sb_err_d;
    end
  end

  assign bus.rs1_sel_o     = rs1_sel;
  assign bus.rs2_sel_o     = rs2_sel;
  assign bus.stall_o       = stall;
  assign bus.issue_ready_o = issue_ready;
  assign bus.sb_err_o      = sb_err_q;

`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] lu_cnt_q, lu_cnt_d;

  // Saturating counters; the load-use counter only counts cycles where
  // no other hazard would have stalled anyway.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    lu_cnt_d    = lu_cnt_q;
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
    if (lu_stall && !sb_stall && !issue_stall && lu_cnt_q != '1)
      lu_cnt_d = lu_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
    end
  end

  assign bus.perf_stall_cnt_o = stall_cnt_q;
  assign bus.perf_lu_cnt_o    = lu_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit
// Directed bench for fwd_hazard_unit with three forwarding sources and a
// four-entry scoreboard. Inputs change one time unit after the rising
// edge; outputs are compared two units later, well clear of the edge.
module tb_fwd_hazard_unit;
  localparam int NSRC = 3;
  localparam int AW   = 5;
  localparam int MAXO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checkCount = 0;
  int   failCount  = 0;

  fwd_hazard_unit_if #(.NUM_FWD_SRC(NSRC), .REG_AW(AW)) bus ();

  fwd_hazard_unit #(
    .NUM_FWD_SRC(NSRC),
    .REG_AW(AW),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    bus.IDEX_rs1_i     = '0;
    bus.IDEX_rs2_i     = '0;
    bus.IDEX_rd_i      = '0;
    bus.IDEX_rd_wren_i = 1'b0;
    bus.fwd_rd_i       = '0;
    bus.fwd_wren_i     = '0;
    bus.fwd_valid_i    = '0;
    bus.issue_i        = 1'b0;
    bus.issue_rd_i     = '0;
    bus.complete_i     = 1'b0;
    bus.complete_rd_i  = '0;
  endtask

  task automatic setSrc(input int k, input logic [AW-1:0] rd, input logic wren,
                        input logic valid);
    bus.fwd_rd_i[k*AW +: AW] = rd;
    bus.fwd_wren_i[k]        = wren;
    bus.fwd_valid_i[k]       = valid;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issueOp(input logic [AW-1:0] rd);
    bus.issue_i    = 1'b1;
    bus.issue_rd_i = rd;
    tick();
    bus.issue_i    = 1'b0;
  endtask

  initial begin
    applyStimulus();
    #12;
    checkOutput("rst_stall", bus.stall_o, 1'b0);
    checkOutput("rst_ready", bus.issue_ready_o, 1'b1);
    checkOutput("rst_sberr", bus.sb_err_o, 1'b0);
    checkOutput("rst_sel1", bus.rs1_sel_o, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Priority: youngest matching source wins
    setSrc(0, 5'd7, 1'b1, 1'b1);
    setSrc(1, 5'd5, 1'b1, 1'b1);
    setSrc(2, 5'd5, 1'b1, 1'b1);
    bus.IDEX_rs1_i = 5'd5;
    bus.IDEX_rs2_i = 5'd7;
    #1;
    checkOutput("prio_sel1", bus.rs1_sel_o, 2'd2);
    checkOutput("prio_sel2", bus.rs2_sel_o, 2'd1);
    checkOutput("prio_stall", bus.stall_o, 1'b0);
    bus.IDEX_rs1_i = 5'd0;
    #1;
    checkOutput("rs0_sel1", bus.rs1_sel_o, 2'd0);
    setSrc(0, 5'd7, 1'b0, 1'b1);
    #1;
    checkOutput("nowren_sel2", bus.rs2_sel_o, 2'd0);
    tick();

    // Load-use
    applyStimulus();
    bus.IDEX_rs2_i = 5'd9;
    setSrc(0, 5'd9, 1'b1, 1'b0);
    setSrc(1, 5'd9, 1'b1, 1'b1);
    #1;
    checkOutput("lu_stall", bus.stall_o, 1'b1);
    checkOutput("lu_sel2", bus.rs2_sel_o, 2'd1);
    tick();
    bus.fwd_valid_i = 3'b111;
    #1;
    checkOutput("lu_release", bus.stall_o, 1'b0);
    applyStimulus();
    bus.IDEX_rs1_i = 5'd11;
    setSrc(2, 5'd11, 1'b1, 1'b0);
    #1;
    checkOutput("lu_src2_sel", bus.rs1_sel_o, 2'd3);
    checkOutput("lu_src2_stall", bus.stall_o, 1'b1);
    tick();

    // Scoreboard RAW timing
    applyStimulus();
    bus.issue_i    = 1'b1;
    bus.issue_rd_i = 5'd12;
    bus.IDEX_rs1_i = 5'd12;
    #1;
    checkOutput("raw_t0", bus.stall_o, 1'b0);
    tick();
    bus.issue_i = 1'b0;
    #1;
    checkOutput("raw_t1", bus.stall_o, 1'b1);
    tick();
    checkOutput("raw_t2", bus.stall_o, 1'b1);
    tick();
    bus.complete_i    = 1'b1;
    bus.complete_rd_i = 5'd12;
    #1;
    checkOutput("raw_t3", bus.stall_o, 1'b1);
    tick();
    bus.complete_i = 1'b0;
    #1;
    checkOutput("raw_t4_stall", bus.stall_o, 1'b0);
    checkOutput("raw_t4_sel", bus.rs1_sel_o, 2'd0);
    checkOutput("raw_t4_err", bus.sb_err_o, 1'b0);

    // WAW and bad complete
    applyStimulus();
    issueOp(5'd3);
    bus.IDEX_rd_i      = 5'd3;
    bus.IDEX_rd_wren_i = 1'b1;
    #1;
    checkOutput("waw_stall", bus.stall_o, 1'b1);
    bus.IDEX_rd_wren_i = 1'b0;
    #1;
    checkOutput("waw_nowren", bus.stall_o, 1'b0);
    bus.complete_i    = 1'b1;
    bus.complete_rd_i = 5'd8;
    tick();
    bus.complete_i = 1'b0;
    #1;
    checkOutput("badcpl_err", bus.sb_err_o, 1'b1);
    issueOp(5'd20);
    issueOp(5'd21);
    checkOutput("badcpl_cnt3", bus.issue_ready_o, 1'b1);
    issueOp(5'd22);
    checkOutput("badcpl_cnt4", bus.issue_ready_o, 1'b0);

    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    checkOutput("midrst_err", bus.sb_err_o, 1'b0);
    checkOutput("midrst_ready", bus.issue_ready_o, 1'b1);
    tick();

    // Fill scoreboard to capacity
    issueOp(5'd1);
    issueOp(5'd2);
    issueOp(5'd3);
    checkOutput("fill3_ready", bus.issue_ready_o, 1'b1);
    issueOp(5'd4);
    checkOutput("fill4_ready", bus.issue_ready_o, 1'b0);
    bus.issue_i    = 1'b1;
    bus.issue_rd_i = 5'd5;
    #1;
    checkOutput("full_issue_stall", bus.stall_o, 1'b1);
    tick();
    bus.issue_i = 1'b0;
    #1;
    checkOutput("drop_err", bus.sb_err_o, 1'b1);
    bus.IDEX_rs1_i = 5'd5;
    #1;
    checkOutput("drop_notbusy", bus.stall_o, 1'b0);
    bus.IDEX_rs1_i = 5'd0;
    bus.issue_i       = 1'b1;
    bus.issue_rd_i    = 5'd5;
    bus.complete_i    = 1'b1;
    bus.complete_rd_i = 5'd1;
    tick();
    bus.issue_i    = 1'b0;
    bus.complete_i = 1'b0;
    bus.IDEX_rs1_i = 5'd5;
    #1;
    checkOutput("swap_busy5", bus.stall_o, 1'b1);
    checkOutput("swap_full", bus.issue_ready_o, 1'b0);
    bus.IDEX_rs1_i = 5'd1;
    #1;
    checkOutput("swap_free1", bus.stall_o, 1'b0);

    // Reset with three ops in flight
    bus.complete_i    = 1'b1;
    bus.complete_rd_i = 5'd2;
    tick();
    bus.complete_i = 1'b0;
    #1;
    checkOutput("inflight3_ready", bus.issue_ready_o, 1'b1);
    rst_n = 1'b0;
    bus.IDEX_rs1_i = 5'd3;
    bus.IDEX_rs2_i = 5'd4;
    #1;
    checkOutput("rst2_stall", bus.stall_o, 1'b0);
    checkOutput("rst2_err", bus.sb_err_o, 1'b0);
    checkOutput("rst2_ready", bus.issue_ready_o, 1'b1);
`ifdef FWD_PERF_CNT_EN
    checkOutput("rst2_perf_stall", bus.perf_stall_cnt_o, 32'd0);
    checkOutput("rst2_perf_lu", bus.perf_lu_cnt_o, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_stall", bus.stall_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
